// File: rtl/espirometro_pkg.sv
// rtl/espirometro_pkg.sv - shared state encodings and default widths for the spirometer volume path
package espirometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_ACUM  = 2'b10,
    ST_DONE  = 2'b11
  } tEstado;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_VOL_W    = 14;
  localparam int DEF_CNT_W    = 12;
  localparam int DEF_NOISE_TH = 4;
  localparam int DEF_HOLD_CNT = 50;
  localparam int DEF_FEV1_N   = 100;

endpackage

// File: rtl/acum_saturado.sv
// rtl/acum_saturado.sv - clipping volume accumulator with sticky saturation flag (clr beats en)
module acum_saturado #(
  parameter int VOL_W  = 14,
  parameter int DATA_W = 8
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [VOL_W-1:0]  sum,
  output logic              sat
);

  // one guard bit catches the overflow of a single add
  logic [VOL_W:0] sumExt;
  assign sumExt = {1'b0, sum} + {{(VOL_W + 1 - DATA_W){1'b0}}, din};

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (sumExt[VOL_W]) begin
        sum <= '1;
        sat <= 1'b1;
      end else begin
        sum <= sumExt[VOL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/volumen_integrador.sv
// rtl/volumen_integrador.sv - manoeuvre FSM integrating flow into volume; VOLUMEN_FEV1_EN adds the FEV1 latch
module volumen_integrador
  import espirometro_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NOISE_TH = DEF_NOISE_TH,
  parameter int HOLD_CNT = DEF_HOLD_CNT,
  parameter int FEV1_N   = DEF_FEV1_N
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iCE,
  input  logic              iStart,
  input  logic [DATA_W-1:0] ivDatos,
  output logic [VOL_W-1:0]  ovVolumen,
  output logic [DATA_W-1:0] ovPico,
  output logic [CNT_W-1:0]  ovMuestras,
  output logic [VOL_W-1:0]  ovFEV1,
  output logic [1:0]        ovEstado,
  output logic              oListo,
  output logic              oSaturado
);

  localparam int Q_W = $clog2(HOLD_CNT + 1);

  if (HOLD_CNT < 1 || FEV1_N < 1) begin : gParamCheck
    $error("volumen_integrador: HOLD_CNT and FEV1_N must be at least 1");
  end

  tEstado         estado, estadoNext;
  logic [Q_W-1:0] quiet, quietNext;
  logic           clr, acc, esRuido;

  assign esRuido = (ivDatos <= DATA_W'(NOISE_TH));

  always_comb begin
    estadoNext = estado;
    clr        = 1'b0;
    acc        = 1'b0;
    quietNext  = esRuido ? quiet + Q_W'(1) : '0;
    if (iStart) begin
      clr        = 1'b1;
      estadoNext = ST_ARMED;
    end else if (iCE) begin
      case (estado)
        ST_ARMED: begin
          if (!esRuido) begin
            acc        = 1'b1;
            estadoNext = ST_ACUM;
          end
        end
        ST_ACUM: begin
          acc = 1'b1;
          if (quietNext == Q_W'(HOLD_CNT)) estadoNext = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      estado     <= ST_IDLE;
      quiet      <= '0;
      ovPico     <= '0;
      ovMuestras <= '0;
    end else begin
      estado <= estadoNext;
      if (clr) begin
        quiet      <= '0;
        ovPico     <= '0;
        ovMuestras <= '0;
      end else if (acc) begin
        quiet <= quietNext;
        if (ivDatos > ovPico) ovPico <= ivDatos;
        if (ovMuestras != '1) ovMuestras <= ovMuestras + CNT_W'(1);
      end
    end
  end

  acum_saturado #(.VOL_W(VOL_W), .DATA_W(DATA_W)) uAcum (
    .iClk    (iClk),
    .iReset_n(iReset_n),
    .clr     (clr),
    .en      (acc),
    .din     (ivDatos),
    .sum     (ovVolumen),
    .sat     (oSaturado)
  );

  assign ovEstado = estado;
  assign oListo   = (estado == ST_DONE);

`ifdef VOLUMEN_FEV1_EN
  localparam int F_W = $clog2(FEV1_N + 1);

  logic [F_W-1:0]   fevCnt;
  logic             fevListo;
  logic [VOL_W-1:0] fev1, volPost;
  logic [VOL_W:0]   sumaPost;

  // post-add volume of the current sample, so FEV1 appears with the same latency as ovVolumen
  assign sumaPost = {1'b0, ovVolumen} + {{(VOL_W + 1 - DATA_W){1'b0}}, ivDatos};
  assign volPost  = sumaPost[VOL_W] ? '1 : sumaPost[VOL_W-1:0];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      fevCnt   <= '0;
      fevListo <= 1'b0;
      fev1     <= '0;
    end else if (clr) begin
      fevCnt   <= '0;
      fevListo <= 1'b0;
      fev1     <= '0;
    end else if (acc && !fevListo) begin
      fevCnt <= fevCnt + F_W'(1);
      if (fevCnt + F_W'(1) == F_W'(FEV1_N) || estadoNext == ST_DONE) begin
        fev1     <= volPost;
        fevListo <= 1'b1;
      end
    end
  end

  assign ovFEV1 = fev1;
`else
  assign ovFEV1 = '0;
`endif

endmodule

// File: tb/tb_volumen_integrador.sv
// tb/tb_volumen_integrador.sv - self-checking bench: vector table, corner sequences, randomized model check
module tb_volumen_integrador;

  localparam int DATA_W   = 8;
  localparam int VOL_W    = 14;
  localparam int CNT_W    = 12;
  localparam int NOISE_TH = 4;
  localparam int HOLD_CNT = 50;
  localparam int FEV1_N   = 4;
  localparam int VOL_MAX  = (1 << VOL_W) - 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              iClk = 1'b0;
  logic              iReset_n, iCE, iStart;
  logic [DATA_W-1:0] ivDatos;
  logic [VOL_W-1:0]  ovVolumen, ovFEV1;
  logic [DATA_W-1:0] ovPico;
  logic [CNT_W-1:0]  ovMuestras;
  logic [1:0]        ovEstado;
  logic              oListo, oSaturado;

  volumen_integrador #(
    .DATA_W(DATA_W), .VOL_W(VOL_W), .CNT_W(CNT_W),
    .NOISE_TH(NOISE_TH), .HOLD_CNT(HOLD_CNT), .FEV1_N(FEV1_N)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iCE(iCE), .iStart(iStart), .ivDatos(ivDatos),
    .ovVolumen(ovVolumen), .ovPico(ovPico), .ovMuestras(ovMuestras), .ovFEV1(ovFEV1),
    .ovEstado(ovEstado), .oListo(oListo), .oSaturado(oSaturado)
  );

  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nErr = 0;

  // reference: 0 idle, 1 armed, 2 accumulating, 3 done
  int mEst, mVol, mPico, mMue, mSat, mQuiet, mFev, mFcnt, mFlat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mEst = 0; mVol = 0; mPico = 0; mMue = 0; mSat = 0;
    mQuiet = 0; mFev = 0; mFcnt = 0; mFlat = 0;
  endfunction

  function automatic void modelSample(int d);
    mVol = mVol + d;
    if (mVol > VOL_MAX) begin
      mVol = VOL_MAX;
      mSat = 1;
    end
    if (mMue < CNT_MAX) mMue++;
    if (d > mPico) mPico = d;
    mQuiet = (d <= NOISE_TH) ? mQuiet + 1 : 0;
    if (mQuiet == HOLD_CNT) mEst = 3;
`ifdef VOLUMEN_FEV1_EN
    if (!mFlat) begin
      mFcnt++;
      if (mFcnt == FEV1_N || mEst == 3) begin
        mFev  = mVol;
        mFlat = 1;
      end
    end
`endif
  endfunction

  function automatic void modelStep(bit st, bit ce, int d);
    if (st) begin
      modelReset();
      mEst = 1;
    end else if (ce) begin
      if (mEst == 1 && d > NOISE_TH) begin
        mEst = 2;
        modelSample(d);
      end else if (mEst == 2) begin
        modelSample(d);
      end
    end
  endfunction

  task automatic cycle(input bit st, input bit ce, input int d);
    iStart  = st;
    iCE     = ce;
    ivDatos = DATA_W'(d);
    @(posedge iClk);
    modelStep(st, ce, d);
    @(negedge iClk);
    iStart = 1'b0;
    iCE    = 1'b0;
  endtask

  task automatic compareModel(input string tag);
    check({tag, ".estado"}, 32'(ovEstado), 32'(mEst));
    check({tag, ".volumen"}, 32'(ovVolumen), 32'(mVol));
    check({tag, ".pico"}, 32'(ovPico), 32'(mPico));
    check({tag, ".muestras"}, 32'(ovMuestras), 32'(mMue));
    check({tag, ".saturado"}, 32'(oSaturado), 32'(mSat));
    check({tag, ".listo"}, 32'(oListo), 32'(mEst == 3));
    check({tag, ".fev1"}, 32'(ovFEV1), 32'(mFev));
  endtask

  typedef struct {
    bit st;
    bit ce;
    int d;
    int vol;
    int pico;
    int mue;
    int est;
  } tVec;

  tVec tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int expVol, expFev, segLeft, d;
    bit quietPh, st, ce;

    tbl[0] = '{1, 1, 100,  0,  0, 0, 1};
    tbl[1] = '{0, 1,   3,  0,  0, 0, 1};
    tbl[2] = '{0, 1,  10, 10, 10, 1, 2};
    tbl[3] = '{0, 1,  20, 30, 20, 2, 2};
    tbl[4] = '{0, 1,   2, 32, 20, 3, 2};
    tbl[5] = '{0, 0,  99, 32, 20, 3, 2};
    tbl[6] = '{0, 1,   7, 39, 20, 4, 2};
    tbl[7] = '{1, 1,  50,  0,  0, 0, 1};

    iReset_n = 1'b0; iCE = 1'b0; iStart = 1'b0; ivDatos = '0;
    modelReset();
    repeat (2) @(negedge iClk);
    iCE = 1'b1; ivDatos = 8'd200;
    @(negedge iClk);
    iReset_n = 1'b1;
    cycle(0, 1, 200);
    check("reset.estado", 32'(ovEstado), 0);
    check("reset.volumen", 32'(ovVolumen), 0);
    check("reset.pico", 32'(ovPico), 0);
    check("reset.muestras", 32'(ovMuestras), 0);
    check("reset.fev1", 32'(ovFEV1), 0);
    check("reset.listo", 32'(oListo), 0);
    check("reset.saturado", 32'(oSaturado), 0);

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].st, tbl[i].ce, tbl[i].d);
      check($sformatf("vec%0d.volumen", i), 32'(ovVolumen), 32'(tbl[i].vol));
      check($sformatf("vec%0d.pico", i), 32'(ovPico), 32'(tbl[i].pico));
      check($sformatf("vec%0d.muestras", i), 32'(ovMuestras), 32'(tbl[i].mue));
      check($sformatf("vec%0d.estado", i), 32'(ovEstado), 32'(tbl[i].est));
    end

    cycle(0, 1, 250);
    cycle(0, 1, 250);
    check("restart.volumen_before", 32'(ovVolumen), 500);
    cycle(1, 0, 0);
    check("restart.volumen", 32'(ovVolumen), 0);
    check("restart.estado", 32'(ovEstado), 1);

    cycle(0, 1, 3);
    cycle(0, 1, 10);
    cycle(0, 1, 20);
    cycle(0, 1, 30);
    for (int i = 1; i <= HOLD_CNT; i++) begin
      cycle(0, 1, 0);
      if (i == HOLD_CNT - 1) check("basic.listo_early", 32'(oListo), 0);
    end
    check("basic.listo", 32'(oListo), 1);
    check("basic.estado", 32'(ovEstado), 3);
    check("basic.volumen", 32'(ovVolumen), 60);
    check("basic.pico", 32'(ovPico), 30);
    check("basic.muestras", 32'(ovMuestras), 53);
    cycle(0, 1, 200);
    check("done.frozen_volumen", 32'(ovVolumen), 60);
    check("done.frozen_pico", 32'(ovPico), 30);

    cycle(1, 0, 0);
    for (int k = 1; k <= 80; k++) begin
      cycle(0, 1, 255);
      expVol = (255 * k > VOL_MAX) ? VOL_MAX : 255 * k;
      check($sformatf("sat%0d.volumen", k), 32'(ovVolumen), 32'(expVol));
      check($sformatf("sat%0d.saturado", k), 32'(oSaturado), 32'(k >= 65));
    end
    cycle(1, 0, 0);
    check("sat.clear_volumen", 32'(ovVolumen), 0);
    check("sat.clear_saturado", 32'(oSaturado), 0);

    for (int k = 0; k < 5; k++) cycle(0, 1, 10);
`ifdef VOLUMEN_FEV1_EN
    expFev = 40;
`else
    expFev = 0;
`endif
    check("fev1.value", 32'(ovFEV1), 32'(expFev));
    check("fev1.volumen", 32'(ovVolumen), 50);

    cycle(1, 0, 0);
    cycle(0, 1, 100);
    cycle(0, 1, 100);
    #2 iReset_n = 1'b0;
    #1;
    check("async.volumen", 32'(ovVolumen), 0);
    check("async.estado", 32'(ovEstado), 0);
    check("async.pico", 32'(ovPico), 0);
    check("async.muestras", 32'(ovMuestras), 0);
    modelReset();
    @(negedge iClk);
    iReset_n = 1'b1;
    compareModel("post_reset");

    cycle(1, 0, 0);
    segLeft = 0;
    quietPh = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (segLeft == 0) begin
        quietPh = 1'($urandom_range(0, 1));
        segLeft = $urandom_range(1, 70);
      end
      segLeft--;
      st = ($urandom_range(0, 299) == 0) || (mEst == 3 && $urandom_range(0, 9) == 0);
      ce = ($urandom_range(0, 3) != 0);
      d  = quietPh ? $urandom_range(0, NOISE_TH) : $urandom_range(0, 255);
      cycle(st, ce, d);
      compareModel("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
